exe_alu_unit: RTL and testbench
===============================

Name: exe_alu_unit

Overview:
Execute-stage arithmetic block of the 5-stage MIPS pipeline. It contains three functions:
- ALU-control decoder: maps the control unit's 4-bit alu_op and the 6-bit funct field to a 5-bit operation code.
- 32-bit ALU: computes result, zero and overflow.
- Branch-target adder.
All outputs are registered once, and sit at the EXE/MEM boundary.

Parameters:
- XLEN, 32, datapath width (fixed at 32; not to be overridden).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_op  in  4  class code from the control unit.
- func  in  6  instruction funct field (bits 5:0).
- shamt  in  5  instruction shift-amount field.
- op1  in  32  forwarded Rs operand.
- op2  in  32  forwarded Rt operand or extended immediate (already muxed upstream).
- pc_plus4  in  32  PC+4 of the instruction in EXE.
- ext_imm  in  32  sign/zero-extended immediate.
- result  out  32  registered ALU result.
- zero  out  1  registered; 1 when the ALU result is 0.
- overflow  out  1  registered signed-overflow flag.
- branch_addr  out  32  registered pc_plus4 + (ext_imm << 2), wrapping modulo 2^32.
- operation  out  5  registered decoded operation (debug/trace).

Behaviour:
- Latency:
  - Decode, ALU and adder are combinational.
  - All five outputs are captured on the rising edge of clk.
  - Outputs are valid one cycle after the inputs are applied.
  - There is no handshake or stall; the block captures every cycle.
- Reset: if rst=1 at a rising edge, then result=0, zero=0, overflow=0, branch_addr=0, operation=5'h1F. Reset overrides new inputs in that cycle.
- alu_op decode:
  - 0000 R-type: use func.
  - 0001 ADD; 0010 SUB; 0011 AND; 0100 OR; 0101 XOR; 0110 SLT; 0111 SLTU; 1000 LUI.
  - Any other alu_op: NOP.
- func decode (R-type):
  - 20 ADD; 21 ADDU; 22 SUB; 23 SUBU.
  - 24 AND; 25 OR; 26 XOR; 27 NOR.
  - 2A SLT; 2B SLTU.
  - 00 SLL; 02 SRL; 03 SRA; 04 SLLV; 06 SRLV; 07 SRAV.
  - Any other func: NOP.
- Operation codes (shared package): ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7, SLT 8, SLTU 9, SLL 10, SRL 11, SRA 12, SLLV 13, SRLV 14, SRAV 15, LUI 16, NOP 31.
- Arithmetic:
  - ADD/ADDU/SUB/SUBU are 32-bit and wrap.
  - SLT compares signed; SLTU compares unsigned. Both give result 1 or 0.
  - SLL/SRL/SRA shift op2 by shamt. SRA is arithmetic.
  - SLLV/SRLV/SRAV shift op2 by op1[4:0].
  - LUI gives {op2[15:0], 16'h0}.
  - NOP gives result 0.
- Overflow:
  - ADD and SUB only: set when the operand signs make the result sign inconsistent.
  - Example: 7FFFFFFF + 1 gives overflow=1.
  - Overflow is 0 for every other operation, including ADDU/SUBU.
  - The result is still written when overflow=1; there is no trap.
- zero is computed from the final 32-bit result for every operation, including NOP (which gives zero=1).
- branch_addr is computed every cycle, independent of alu_op.

Decomposition:
- Package exe_alu_pkg holds:
  - the alu_op class constants;
  - the funct constants;
  - the 5-bit operation constants;
  - the NOP and reset value.
- One natural sub-module, alu_ctrl_dec: the purely combinational alu_op/func → operation decoder.
- The ALU, branch adder and output register stay in the top module.

Test Plan:
- Reset, then an add: rst=1 for one edge → result=0, zero=0, overflow=0, branch_addr=0, operation=31. Then rst=0 with alu_op=0001, op1=0, op2=4 → next edge result=4, zero=0.
- addi chain: for k=1..8, set alu_op=0001, op1=4(k−1), op2=4 → result=4k each cycle (4, 8, …, 32), one-cycle latency, no bubbles.
- Signed overflow and SLT vs SLTU:
  - R-type ADD, op1=7FFFFFFF, op2=1 → result=80000000, overflow=1.
  - Same operands with ADDU → overflow=0.
  - SLT with FFFFFFFF vs 1 → result=1; SLTU with the same operands → result=0.
- Shifts:
  - SRA, op2=80000000, shamt=4 → F8000000.
  - SRL with the same operands → 08000000.
  - SLLV, op1=3, op2=1 → 8.
  - LUI, op2=1234 → 12340000.
- Branch and zero:
  - alu_op=0010, op1=op2=5 → zero=1.
  - pc_plus4=204, ext_imm=FFFFFFFE → branch_addr=1FC.
  - ext_imm=3 → 210.
- Undefined codes: func=3F, or alu_op=1111 → operation=31, result=0, zero=1, overflow=0.

Source files
------------

// File: rtl/exe_alu_pkg.sv
// Shared constants for the EXE-stage arithmetic block: alu_op classes,
// R-type funct codes and the 5-bit operation encoding.
package exe_alu_pkg;
    localparam int XLEN = 32;

    // alu_op classes from the control unit
    localparam logic [3:0] AOP_RTYPE = 4'b0000;
    localparam logic [3:0] AOP_ADD   = 4'b0001;
    localparam logic [3:0] AOP_SUB   = 4'b0010;
    localparam logic [3:0] AOP_AND   = 4'b0011;
    localparam logic [3:0] AOP_OR    = 4'b0100;
    localparam logic [3:0] AOP_XOR   = 4'b0101;
    localparam logic [3:0] AOP_SLT   = 4'b0110;
    localparam logic [3:0] AOP_SLTU  = 4'b0111;
    localparam logic [3:0] AOP_LUI   = 4'b1000;

    // R-type funct field
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // decoded operation
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [4:0] OP_SLL  = 5'd10;
    localparam logic [4:0] OP_SRL  = 5'd11;
    localparam logic [4:0] OP_SRA  = 5'd12;
    localparam logic [4:0] OP_SLLV = 5'd13;
    localparam logic [4:0] OP_SRLV = 5'd14;
    localparam logic [4:0] OP_SRAV = 5'd15;
    localparam logic [4:0] OP_LUI  = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd31;
    localparam logic [4:0] OP_RST  = OP_NOP;
endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU-control decoder: alu_op class plus funct field to 5-bit operation.
module alu_ctrl_dec
    import exe_alu_pkg::*;
(
    input  logic [3:0] alu_op,
    input  logic [5:0] func,
    output logic [4:0] operation
);
    logic [4:0] rtype_op;

    always_comb begin
        rtype_op = OP_NOP;
        case (func)
            FN_ADD:  rtype_op = OP_ADD;
            FN_ADDU: rtype_op = OP_ADDU;
            FN_SUB:  rtype_op = OP_SUB;
            FN_SUBU: rtype_op = OP_SUBU;
            FN_AND:  rtype_op = OP_AND;
            FN_OR:   rtype_op = OP_OR;
            FN_XOR:  rtype_op = OP_XOR;
            FN_NOR:  rtype_op = OP_NOR;
            FN_SLT:  rtype_op = OP_SLT;
            FN_SLTU: rtype_op = OP_SLTU;
            FN_SLL:  rtype_op = OP_SLL;
            FN_SRL:  rtype_op = OP_SRL;
            FN_SRA:  rtype_op = OP_SRA;
            FN_SLLV: rtype_op = OP_SLLV;
            FN_SRLV: rtype_op = OP_SRLV;
            FN_SRAV: rtype_op = OP_SRAV;
            default: rtype_op = OP_NOP;
        endcase
    end

    always_comb begin
        operation = OP_NOP;
        case (alu_op)
            AOP_RTYPE: operation = rtype_op;
            AOP_ADD:   operation = OP_ADD;
            AOP_SUB:   operation = OP_SUB;
            AOP_AND:   operation = OP_AND;
            AOP_OR:    operation = OP_OR;
            AOP_XOR:   operation = OP_XOR;
            AOP_SLT:   operation = OP_SLT;
            AOP_SLTU:  operation = OP_SLTU;
            AOP_LUI:   operation = OP_LUI;
            default:   operation = OP_NOP;
        endcase
    end
endmodule

// File: rtl/exe_alu_unit.sv
// EXE-stage arithmetic: decoder, 32-bit ALU and branch-target adder,
// all outputs registered at the EXE/MEM boundary.
module exe_alu_unit
    import exe_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      alu_op,
    input  logic [5:0]      func,
    input  logic [4:0]      shamt,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] ext_imm,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic [XLEN-1:0] branch_addr,
    output logic [4:0]      operation
);
    logic [4:0]      op_dec;
    logic [XLEN-1:0] sum, diff, alu_res, br_next;
    logic            alu_ovf;

    alu_ctrl_dec u_dec (
        .alu_op    (alu_op),
        .func      (func),
        .operation (op_dec)
    );

    assign sum     = op1 + op2;
    assign diff    = op1 - op2;
    assign br_next = pc_plus4 + (ext_imm << 2);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_dec)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (op1[XLEN-1] == op2[XLEN-1]) && (sum[XLEN-1] != op1[XLEN-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (op1[XLEN-1] != op2[XLEN-1]) && (diff[XLEN-1] != op1[XLEN-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_NOR:  alu_res = ~(op1 | op2);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            OP_SLL:  alu_res = op2 << shamt;
            OP_SRL:  alu_res = op2 >> shamt;
            OP_SRA:  alu_res = $signed(op2) >>> shamt;
            OP_SLLV: alu_res = op2 << op1[4:0];
            OP_SRLV: alu_res = op2 >> op1[4:0];
            OP_SRAV: alu_res = $signed(op2) >>> op1[4:0];
            OP_LUI:  alu_res = {op2[15:0], 16'h0000};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            branch_addr <= '0;
            operation   <= OP_RST;
        end else begin
            result      <= alu_res;
            zero        <= (alu_res == '0);
            overflow    <= alu_ovf;
            branch_addr <= br_next;
            operation   <= op_dec;
        end
    end
endmodule

// File: tb/tb_exe_alu_unit.sv
// Directed bench for exe_alu_unit with hand-computed expected values.
module tb_exe_alu_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] op1, op2, pc_plus4, ext_imm;
    logic [31:0] result, branch_addr;
    logic        zero, overflow;
    logic [4:0]  operation;

    int n_cmp = 0;
    int n_err = 0;

    exe_alu_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_op      (alu_op),
        .func        (func),
        .shamt       (shamt),
        .op1         (op1),
        .op2         (op2),
        .pc_plus4    (pc_plus4),
        .ext_imm     (ext_imm),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .branch_addr (branch_addr),
        .operation   (operation)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // apply inputs, then sample 1 time unit after the capturing edge
    task automatic step(input logic [3:0] a, input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] x, input logic [31:0] y);
        alu_op = a; func = f; shamt = sh; op1 = x; op2 = y;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] r, input logic z,
                           input logic v, input logic [4:0] op);
        chk({tag, ".result"}, result, r);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
        chk({tag, ".ovf"}, {31'b0, overflow}, {31'b0, v});
        chk({tag, ".op"}, {27'b0, operation}, {27'b0, op});
    endtask

    initial begin
        rst = 1'b1; pc_plus4 = 32'h0000_0204; ext_imm = 32'h3;
        step(4'b0001, 6'h00, 5'd0, 32'h1, 32'h1);
        chk_all("reset", 32'h0, 1'b0, 1'b0, 5'd31);
        chk("reset.br", branch_addr, 32'h0);

        rst = 1'b0; pc_plus4 = 32'h0; ext_imm = 32'h0;
        step(4'b0001, 6'h00, 5'd0, 32'h0, 32'h4);
        chk_all("add0", 32'h4, 1'b0, 1'b0, 5'd0);

        for (int k = 1; k <= 8; k++) begin
            step(4'b0001, 6'h00, 5'd0, 32'(4 * (k - 1)), 32'h4);
            chk($sformatf("addi%0d", k), result, 32'(4 * k));
        end

        step(4'b0000, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1);
        chk_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 5'd0);
        step(4'b0000, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1);
        chk_all("addu", 32'h8000_0000, 1'b0, 1'b0, 5'd1);
        step(4'b0000, 6'h22, 5'd0, 32'h8000_0000, 32'h1);
        chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 5'd2);
        step(4'b0000, 6'h23, 5'd0, 32'h8000_0000, 32'h1);
        chk_all("subu", 32'h7FFF_FFFF, 1'b0, 1'b0, 5'd3);
        step(4'b0000, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h1);
        chk_all("slt", 32'h1, 1'b0, 1'b0, 5'd8);
        step(4'b0000, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h1);
        chk_all("sltu", 32'h0, 1'b1, 1'b0, 5'd9);
        step(4'b0110, 6'h3F, 5'd0, 32'h8000_0000, 32'h0);
        chk_all("slt_i", 32'h1, 1'b0, 1'b0, 5'd8);
        step(4'b0000, 6'h27, 5'd0, 32'h0F0F_0F0F, 32'h00FF_00FF);
        chk_all("nor", 32'hF000_F000, 1'b0, 1'b0, 5'd7);
        step(4'b0101, 6'h00, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        chk_all("xor_i", 32'hF00F_F00F, 1'b0, 1'b0, 5'd6);
        step(4'b0011, 6'h00, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        chk_all("and_i", 32'h0F00_0F00, 1'b0, 1'b0, 5'd4);
        step(4'b0100, 6'h00, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
        chk_all("or_i", 32'hFF0F_FF0F, 1'b0, 1'b0, 5'd5);

        step(4'b0000, 6'h03, 5'd4, 32'h0, 32'h8000_0000);
        chk_all("sra", 32'hF800_0000, 1'b0, 1'b0, 5'd12);
        step(4'b0000, 6'h02, 5'd4, 32'h0, 32'h8000_0000);
        chk_all("srl", 32'h0800_0000, 1'b0, 1'b0, 5'd11);
        step(4'b0000, 6'h00, 5'd8, 32'h0, 32'h0000_00A5);
        chk_all("sll", 32'h0000_A500, 1'b0, 1'b0, 5'd10);
        step(4'b0000, 6'h04, 5'd0, 32'h3, 32'h1);
        chk_all("sllv", 32'h8, 1'b0, 1'b0, 5'd13);
        step(4'b0000, 6'h06, 5'd0, 32'h24, 32'hF000_0000);
        chk_all("srlv", 32'h0F00_0000, 1'b0, 1'b0, 5'd14);
        step(4'b0000, 6'h07, 5'd0, 32'h8, 32'h8000_0000);
        chk_all("srav", 32'hFF80_0000, 1'b0, 1'b0, 5'd15);
        step(4'b1000, 6'h00, 5'd0, 32'h0, 32'hABCD_1234);
        chk_all("lui", 32'h1234_0000, 1'b0, 1'b0, 5'd16);

        pc_plus4 = 32'h0000_0204; ext_imm = 32'hFFFF_FFFE;
        step(4'b0010, 6'h00, 5'd0, 32'h5, 32'h5);
        chk_all("sub_zero", 32'h0, 1'b1, 1'b0, 5'd2);
        chk("br_neg", branch_addr, 32'h0000_01FC);
        ext_imm = 32'h3;
        step(4'b1111, 6'h20, 5'd0, 32'h5, 32'h7);
        chk("br_pos", branch_addr, 32'h0000_0210);
        chk_all("aop_undef", 32'h0, 1'b1, 1'b0, 5'd31);
        step(4'b0000, 6'h3F, 5'd0, 32'h5, 32'h7);
        chk_all("fn_undef", 32'h0, 1'b1, 1'b0, 5'd31);

        rst = 1'b1;
        step(4'b0000, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1);
        chk_all("rst_ovr", 32'h0, 1'b0, 1'b0, 5'd31);
        chk("rst_ovr.br", branch_addr, 32'h0);
        rst = 1'b0;
        step(4'b0000, 6'h21, 5'd0, 32'h1, 32'h2);
        chk_all("post_rst", 32'h3, 1'b0, 1'b0, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
